board_disp_scan: RTL
====================

# board_disp_scan

Parametrised multi-digit seven-segment scan driver for the Basys3 game boards. It sits between the game-state logic and the board's anode and cathode pins. It time-multiplexes NUM_DIG digits: the leftmost digit shows the current-player glyph, and the remaining digits each show one column of a 3-row cell grid. Cells can be off, lit or blinking. It also has whole-display win/tie message modes and a frame-tick output.

## Interface
Parameters:
- NUM_DIG, 4: digit count (>=2); the grid has NUM_DIG-1 columns by 3 rows, so NCELL = 3*(NUM_DIG-1).
- SCAN_DIV, 2200: CLK cycles per digit slot (>=1).
- BLINK_DIV, 10000000: CLK cycles per blink half-period (>=1).

Ports:
- CLK  in  1  system clock; one clock domain only.
- RST  in  1  reset, synchronous and active-high.
- cells  in  2*NCELL  2-bit cell code per cell; cell k is cells[2k+1:2k], with k = row*(NUM_DIG-1) + col.
- player  in  1  current player: 0 means player 1, 1 means player 2.
- win  in  2  display mode: 0 game, 1 P1 wins, 2 P2 wins, 3 tie.
- DISP_EN  out  NUM_DIG  active-low digit enables; bit i drives digit i, with digit 0 rightmost.
- SEGMENTS  out  8  active-low cathodes, {A,B,C,D,E,F,G,DP} with bit 7 = A.
- frame_tick  out  1  one-cycle pulse when the digit index wraps from NUM_DIG-1 to 0.

## Operation
- Scan prescaler: counts 0..SCAN_DIV-1 and issues step on its terminal count.
- Digit index: idx advances on step and wraps from NUM_DIG-1 to 0.
- Blink prescaler: counts 0..BLINK_DIV-1 and toggles blink on its terminal count; blink=0 means the lit phase.
- Output register: DISP_EN and SEGMENTS are recomputed every cycle from idx, the inputs and blink.
- DISP_EN = all ones, with bit idx cleared.
- Mode win=0:
  - idx = NUM_DIG-1: player glyph; player=0 gives 8'b10011111 ("1"), player=1 gives 8'b00100101 ("2").
  - Other idx, column col = idx: row 0 drives D (bit 4), row 1 drives G (bit 1), row 2 drives A (bit 7).
  - Cell codes: 0 and 3 drive 1 (off), 1 drives 0 (on), 2 drives blink.
  - All unused segment bits are 1.
- Mode win=1: every digit shows 8'b10011111 | {8{blink}}.
- Mode win=2: every digit shows 8'b00100101 | {8{blink}}.
- Mode win=3 (no blink):
  - Digit NUM_DIG-1: 8'b11100001 ("t").
  - Digit 1: 8'b01100001 ("E").
  - Digit 0: 8'b10011111 ("I").
  - All other digits: 8'hFF.
  - If NUM_DIG=2, the "t" glyph wins over "E" on digit 1.
- Input changes, including a win change mid-scan, take effect on the next registered update. Scan position and blink phase are never reset by a mode change.

## Timing
- Reset values: DISP_EN all ones, SEGMENTS 8'hFF, frame_tick 0, idx 0, both prescalers 0, blink 0.
- DISP_EN and SEGMENTS are registered together. They change on the same edge, one cycle after idx or any input changes, so there is no ghosting between digits.
- First cycle after RST deasserts: outputs show digit 0.
- Digit period is SCAN_DIV cycles; the frame is NUM_DIG*SCAN_DIV cycles.
- frame_tick is registered and asserts on the same edge that DISP_EN selects digit 0 after the wrap.
- Blink toggles every BLINK_DIV cycles, independently of the scan.
- RST asserted mid-operation: next edge forces all reset values, regardless of step or blink events on that edge.
- SCAN_DIV=1: idx advances every cycle.

## Configuration
Feature macro DP_CURSOR_EN (a cursor indicator on the decimal point):
- Defined:
  - Adds input cursor_vld (1 bit) and input cursor ($clog2(NUM_DIG) bits, selecting a column 0..NUM_DIG-2).
  - In win=0, with cursor_vld=1 and idx==cursor, DP (bit 0) is driven ~blink, i.e. anti-phase with cell blink.
  - DP is 1 in every other case.
  - A cursor value >= NUM_DIG-1 lights no DP.
- Undefined: no cursor ports exist, and DP is constant 1.

## Structure
- Package board_disp_pkg holds:
  - glyph constants GLY_1, GLY_2, GLY_T, GLY_E, GLY_I, GLY_BLANK;
  - cell code constants CELL_OFF, CELL_ON, CELL_BLINK;
  - segment bit index constants SEG_A..SEG_DP;
  - the win-mode enum.
- Sub-module tick_div (parameter DIV, ports CLK, RST, tick) is a pulse prescaler, instantiated twice: once for scan, once for blink.

## Test plan
Bench parameters: NUM_DIG=4, SCAN_DIV=4, BLINK_DIV=16.
- Reset: RST high 3 cycles, then low -> DISP_EN=4'b1111 and SEGMENTS=8'hFF while RST is high; 4'b1110 on the first cycle after release; frame_tick first pulses 16 cycles later.
- Player glyph: win=0, player=1, all cells 0 -> digit 3 shows 8'b00100101; digits 0-2 show 8'hFF; player=0 gives 8'b10011111 on digit 3.
- Cell mapping: cell0=1, cell4=1, cell8=2 (others 0) ->
  - digit 0: bit 4 = 0;
  - digit 1: bit 1 = 0;
  - digit 2: bit 7 follows blink, toggling every 16 cycles.
- Tie: win=3 -> digits 0..3 show 10011111, 01100001, 11111111, 11100001 in scan order.
- Mid-scan win: win 0->2 while digit 1 is active -> the next cycle shows 8'b00100101 when blink=0 and 8'hFF when blink=1; idx continues without restarting.
- Mid-scan reset: RST for 1 cycle while digit 2 is active -> next edge gives all reset values; scan restarts at digit 0.
- DP_CURSOR_EN defined: cursor_vld=1, cursor=1 -> DP of digit 1 is ~blink; DP is 1 on all other digits and whenever win!=0.

Source files
------------

// File: rtl/board_disp_pkg.sv
// Shared constants for the Basys3 game-board scan driver: glyph bytes,
// cell codes, segment bit positions and the display-mode enum.
// Segment bytes are active-low {A,B,C,D,E,F,G,DP}, bit 7 = A.
package board_disp_pkg;

  localparam logic [7:0] GLY_1     = 8'b10011111;
  localparam logic [7:0] GLY_2     = 8'b00100101;
  localparam logic [7:0] GLY_T     = 8'b11100001;
  localparam logic [7:0] GLY_E     = 8'b01100001;
  localparam logic [7:0] GLY_I     = 8'b10011111;
  localparam logic [7:0] GLY_BLANK = 8'hFF;

  localparam logic [1:0] CELL_OFF   = 2'd0;
  localparam logic [1:0] CELL_ON    = 2'd1;
  localparam logic [1:0] CELL_BLINK = 2'd2;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  typedef enum logic [1:0] {
    WIN_GAME = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2,
    WIN_TIE  = 2'd3
  } win_mode_e;

  // Active-low segment level for one cell; code 3 is treated as off.
  function automatic logic cell_seg(input logic [1:0] code, input logic blink);
    case (code)
      CELL_ON:    return 1'b0;
      CELL_BLINK: return blink;
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/board_disp_scan_tick_div.sv
// tick_div: free-running prescaler, counts 0..DIV-1 and raises tick
// during the terminal-count cycle. Synchronous active-high reset.
module tick_div #(
  parameter int DIV = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Terminal count detection and wrap-around of the counter.
  always_comb begin
    tick  = (cnt_q == TERM);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/board_disp_scan.sv
// board_disp_scan: multiplexed seven-segment driver. Leftmost digit shows
// the current player, the others show one column of a 3-row cell grid.
// Optional DP cursor indicator enabled by defining DP_CURSOR_EN.
module board_disp_scan
  import board_disp_pkg::*;
#(
  parameter int NUM_DIG   = 4,
  parameter int SCAN_DIV  = 2200,
  parameter int BLINK_DIV = 10000000
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [6*(NUM_DIG-1)-1:0]     cells,
  input  logic                         player,
  input  logic [1:0]                   win,
`ifdef DP_CURSOR_EN
  input  logic                         cursor_vld,
  input  logic [$clog2(NUM_DIG)-1:0]   cursor,
`endif
  output logic [NUM_DIG-1:0]           DISP_EN,
  output logic [7:0]                   SEGMENTS,
  output logic                         frame_tick
);

  localparam int IDXW  = $clog2(NUM_DIG);
  localparam int CELLW = 6*(NUM_DIG-1);
  localparam int SELW  = (CELLW > 2) ? $clog2(CELLW) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_DIG - 1);

  logic scan_step, blink_step;

  tick_div #(.DIV(SCAN_DIV))  u_scan_div  (.CLK(CLK), .RST(RST), .tick(scan_step));
  tick_div #(.DIV(BLINK_DIV)) u_blink_div (.CLK(CLK), .RST(RST), .tick(blink_step));

  logic [IDXW-1:0]    idx_q, idx_d;
  logic               blink_q, blink_d;
  logic               wrap_q, wrap_d;
  logic               frame_tick_q, frame_tick_d;
  logic [NUM_DIG-1:0] disp_en_q, disp_en_d;
  logic [7:0]         seg_q, seg_d;

  win_mode_e       mode;
  logic [IDXW-1:0] col;
  logic [SELW-1:0] sel_r0, sel_r1, sel_r2;

  // Scan index, blink phase and frame-tick pipeline; frame_tick is delayed
  // one cycle after the wrap so it lines up with digit 0 reaching the pins.
  always_comb begin
    idx_d = idx_q;
    if (scan_step) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    blink_d      = blink_q ^ blink_step;
    wrap_d       = scan_step && (idx_q == LAST_IDX);
    frame_tick_d = wrap_q;
  end

  // Digit enable and segment pattern for the currently selected digit.
  always_comb begin
    mode   = win_mode_e'(win);
    col    = (idx_q == LAST_IDX) ? '0 : idx_q;
    sel_r0 = SELW'(2 * int'(col));
    sel_r1 = SELW'(2 * (NUM_DIG - 1 + int'(col)));
    sel_r2 = SELW'(2 * (2 * (NUM_DIG - 1) + int'(col)));

    disp_en_d         = '1;
    disp_en_d[idx_q]  = 1'b0;
    seg_d             = GLY_BLANK;

    case (mode)
      WIN_GAME: begin
        if (idx_q == LAST_IDX) begin
          seg_d = player ? GLY_2 : GLY_1;
        end else begin
          seg_d[SEG_D] = cell_seg(cells[sel_r0 +: 2], blink_q);
          seg_d[SEG_G] = cell_seg(cells[sel_r1 +: 2], blink_q);
          seg_d[SEG_A] = cell_seg(cells[sel_r2 +: 2], blink_q);
        end
      end
      WIN_P1: seg_d = GLY_1 | {8{blink_q}};
      WIN_P2: seg_d = GLY_2 | {8{blink_q}};
      default: begin
        // Leftmost check first so "t" wins over "E" when NUM_DIG is 2.
        if (idx_q == LAST_IDX)        seg_d = GLY_T;
        else if (idx_q == IDXW'(1))   seg_d = GLY_E;
        else if (idx_q == '0)         seg_d = GLY_I;
        else                          seg_d = GLY_BLANK;
      end
    endcase

`ifdef DP_CURSOR_EN
    if (mode == WIN_GAME && cursor_vld && cursor == idx_q && idx_q != LAST_IDX)
      seg_d[SEG_DP] = ~blink_q;
`endif
  end

  // State and output registers; reset overrides any step/blink on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_q        <= '0;
      blink_q      <= 1'b0;
      wrap_q       <= 1'b0;
      frame_tick_q <= 1'b0;
      disp_en_q    <= '1;
      seg_q        <= GLY_BLANK;
    end else begin
      idx_q        <= idx_d;
      blink_q      <= blink_d;
      wrap_q       <= wrap_d;
      frame_tick_q <= frame_tick_d;
      disp_en_q    <= disp_en_d;
      seg_q        <= seg_d;
    end
  end

  assign DISP_EN    = disp_en_q;
  assign SEGMENTS   = seg_q;
  assign frame_tick = frame_tick_q;

endmodule
